// File: rtl/writeback_queue_unit.sv
// writeback_queue_unit
//   Writeback stage with a result queue. It picks the ALU or memory result and
//   formats load data: byte, half or word extract with sign or zero extension.
//   Writes to x0 are suppressed. Completed results are buffered in a FIFO that
//   drains to the register file through a valid/ready handshake.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset; release is synchronous
//   in_valid     producer has a result this cycle
//   in_ready     queue can accept a result (not full and not in reset)
//   opWrite      result targets the register file
//   opSel        1 selects memory_data, 0 selects ALU_Result
//   opReg        destination register index
//   mem_size     00 byte, 01 half, 10 word, 11 doubleword (word when 32-bit)
//   mem_unsigned 1 zero-extends, 0 sign-extends
//   addr_lsb     low address bits of the load (byte offset in the word)
//   ALU_Result   execute result
//   memory_data  raw aligned memory word
//   rf_ready     register file accepts the write
//   write        head entry writes this cycle
//   write_reg    head destination register (0 when the queue is empty)
//   write_data   head data (0 when the queue is empty)
//   occupancy    number of entries held
//   retired      count of committed writes, saturating (WB_RETIRE_CNT_EN only)
//   report       prints a per-cycle status line in simulation
//
// Build option
//   WB_RETIRE_CNT_EN : adds the 32-bit retired-write counter output.
module writeback_queue_unit #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              opWrite,
  input  logic                              opSel,
  input  logic [REG_ADDR_W-1:0]             opReg,
  input  logic [1:0]                        mem_size,
  input  logic                              mem_unsigned,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   addr_lsb,
  input  logic [DATA_WIDTH-1:0]             ALU_Result,
  input  logic [DATA_WIDTH-1:0]             memory_data,
  input  logic                              rf_ready,
  output logic                              write,
  output logic [REG_ADDR_W-1:0]             write_reg,
  output logic [DATA_WIDTH-1:0]             write_data,
  output logic [$clog2(FIFO_DEPTH):0]       occupancy,
`ifdef WB_RETIRE_CNT_EN
  output logic [31:0]                       retired,
`endif
  input  logic                              report
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Extract the addressed lane and extend it to the full datapath width.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [DATA_WIDTH-1:0] raw,
    input logic [1:0]            size,
    input logic                  zext,
    input logic [OFF_W-1:0]      off
  );
    logic [OFF_W-1:0]      lane_off;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] res;
    // Offsets are aligned down to the access size; for a 32-bit word access
    // this clears every offset bit so addr_lsb is ignored.
    case (size)
      2'b00:   lane_off = off;
      2'b01:   lane_off = off & ~OFF_W'(1);
      default: lane_off = off & ~OFF_W'(3);
    endcase
    sh  = raw >> {lane_off, 3'b000};
    res = raw;
    case (size)
      2'b00: begin
        if (zext) res = DATA_WIDTH'(sh[7:0]);
        else      res = DATA_WIDTH'($signed(sh[7:0]));
      end
      2'b01: begin
        if (zext) res = DATA_WIDTH'(sh[15:0]);
        else      res = DATA_WIDTH'($signed(sh[15:0]));
      end
      default: begin
        if (size == 2'b11 && DATA_WIDTH != 32) res = raw;
        else if (zext) res = DATA_WIDTH'(sh[31:0]);
        else           res = DATA_WIDTH'($signed(sh[31:0]));
      end
    endcase
    return res;
  endfunction

  // ---- p0: combinational formatting at the queue input ----
  logic [DATA_WIDTH-1:0] fmt_data_p0;
  logic                  fmt_wr_p0;

  always_comb begin
    fmt_data_p0 = ALU_Result;
    if (opSel) fmt_data_p0 = fmt_load(memory_data, mem_size, mem_unsigned, addr_lsb);
    fmt_wr_p0 = opWrite && (opReg != '0);
  end

  // ---- p1: result queue storage and control ----
  logic [DATA_WIDTH-1:0] data_p1 [FIFO_DEPTH];
  logic [REG_ADDR_W-1:0] reg_p1  [FIFO_DEPTH];
  logic                  wr_p1   [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty, full, head_wr, push, pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign head_wr  = wr_p1[rd_ptr];
  // in_ready depends only on fullness; a pop at full does not admit a push.
  assign in_ready = reset && !full;
  assign push     = in_valid && in_ready;
  // Non-writing entries leave without waiting on the register file.
  assign pop      = !empty && (rf_ready || !head_wr);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_p1[wr_ptr] <= fmt_data_p0;
      reg_p1[wr_ptr]  <= opReg;
      wr_p1[wr_ptr]   <= fmt_wr_p0;
    end
  end

  // ---- head outputs ----
  assign write      = !empty && head_wr;
  assign write_reg  = empty ? '0 : reg_p1[rd_ptr];
  assign write_data = empty ? '0 : data_p1[rd_ptr];
  assign occupancy  = count;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                retired <= '0;
    else if (pop && head_wr && retired != '1)  retired <= retired + 32'd1;
  end
`endif

  logic [31:0] cycle_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report) begin
`ifdef WB_RETIRE_CNT_EN
      $display("wbq core=%0d cycle=%0d write=%0b reg=%0d data=%h occ=%0d retired=%0d",
               CORE, cycle_q, write, write_reg, write_data, occupancy, retired);
`else
      $display("wbq core=%0d cycle=%0d write=%0b reg=%0d data=%h occ=%0d",
               CORE, cycle_q, write, write_reg, write_data, occupancy);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue_unit.sv
// tb_writeback_queue_unit
//   Directed bench for writeback_queue_unit at the default configuration
//   (32-bit datapath, two-entry queue). Inputs change on the falling edge and
//   outputs are compared on the falling edge after the capturing rising edge.
module tb_writeback_queue_unit;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        opWrite;
  logic        opSel;
  logic [4:0]  opReg;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [1:0]  addr_lsb;
  logic [31:0] ALU_Result;
  logic [31:0] memory_data;
  logic        rf_ready;
  logic        write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [1:0]  occupancy;
  logic        report;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int checks   = 0;
  int failures = 0;

  writeback_queue_unit dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opWrite      (opWrite),
    .opSel        (opSel),
    .opReg        (opReg),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .addr_lsb     (addr_lsb),
    .ALU_Result   (ALU_Result),
    .memory_data  (memory_data),
    .rf_ready     (rf_ready),
    .write        (write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .occupancy    (occupancy),
`ifdef WB_RETIRE_CNT_EN
    .retired      (retired),
`endif
    .report       (report)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic wr, input logic sel, input logic [4:0] rg,
                       input logic [1:0] sz, input logic uns, input logic [1:0] lsb,
                       input logic [31:0] alu, input logic [31:0] mem);
    in_valid     = v;
    opWrite      = wr;
    opSel        = sel;
    opReg        = rg;
    mem_size     = sz;
    mem_unsigned = uns;
    addr_lsb     = lsb;
    ALU_Result   = alu;
    memory_data  = mem;
  endtask

  typedef struct packed {
    logic        sel;
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  lsb;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 2'b00, 1'b0, 2'd2, 32'h0, 32'h0080_0000, 32'hFFFF_FF80};
    vecs[1] = '{1'b1, 2'b01, 1'b1, 2'd3, 32'h0, 32'hBEEF_1234, 32'h0000_BEEF};
    vecs[2] = '{1'b1, 2'b01, 1'b0, 2'd0, 32'h0, 32'hBEEF_8234, 32'hFFFF_8234};
    vecs[3] = '{1'b1, 2'b00, 1'b1, 2'd3, 32'h0, 32'h8012_3456, 32'h0000_0080};
    vecs[4] = '{1'b1, 2'b00, 1'b0, 2'd1, 32'h0, 32'h1234_7F56, 32'h0000_007F};
    vecs[5] = '{1'b1, 2'b10, 1'b0, 2'd3, 32'h0, 32'h89AB_CDEF, 32'h89AB_CDEF};
    vecs[6] = '{1'b1, 2'b11, 1'b1, 2'd0, 32'h0, 32'h0123_4567, 32'h0123_4567};
    vecs[7] = '{1'b0, 2'b00, 1'b0, 2'd2, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF};

    reset    = 1'b0;
    rf_ready = 1'b0;
    report   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 32'h0, 32'h0);

    // Reset state, with in_valid asserted to show it is ignored.
    tick();
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_write", write, 0);
    check("rst_write_reg", write_reg, 0);
    check("rst_write_data", write_data, 0);
    check("rst_occ", occupancy, 0);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Load formatting and ALU pass-through, one push and drain per vector.
    rf_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1'b1, 1'b1, vecs[i].sel, 5'(5 + i), vecs[i].sz, vecs[i].uns, vecs[i].lsb,
            vecs[i].alu, vecs[i].mem);
      tick();
      check($sformatf("fmt%0d_data", i), write_data, vecs[i].exp);
      check($sformatf("fmt%0d_write", i), write, 1);
      check($sformatf("fmt%0d_reg", i), write_reg, 5 + i);
      in_valid = 1'b0;
      tick();
      check($sformatf("fmt%0d_drain", i), occupancy, 0);
    end

    // x0 suppression: drains without rf_ready.
    rf_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0, 2'd0, 32'd7, 32'h0);
    tick();
    in_valid = 1'b0;
    check("x0_write", write, 0);
    check("x0_occ1", occupancy, 1);
    tick();
    check("x0_occ0", occupancy, 0);
    check("x0_empty_data", write_data, 0);

    // Backpressure: queue fills at two, third result held, then in-order drain.
    drive(1'b1, 1'b1, 1'b0, 5'd7, 2'b00, 1'b0, 2'd0, 32'd1, 32'h0);
    tick();
    check("bp_occ1", occupancy, 1);
    check("bp_ready1", in_ready, 1);
    ALU_Result = 32'd2;
    tick();
    check("bp_occ2", occupancy, 2);
    check("bp_ready_full", in_ready, 0);
    ALU_Result = 32'd3;
    tick();
    check("bp_held_occ", occupancy, 2);
    check("bp_held_ready", in_ready, 0);
    check("bp_head1", write_data, 1);
    check("bp_head1_wr", write, 1);
    rf_ready = 1'b1;
    tick();
    check("bp_head2", write_data, 2);
    check("bp_occ_after_pop", occupancy, 1);
    tick();
    in_valid = 1'b0;
    check("bp_head3", write_data, 3);
    check("bp_pushpop_occ", occupancy, 1);
    tick();
    check("bp_drained", occupancy, 0);
    check("bp_drained_wr", write, 0);

    // Reset asserted mid-operation with two entries held.
    rf_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 5'd9, 2'b00, 1'b0, 2'd0, 32'd10, 32'h0);
    tick();
    ALU_Result = 32'd11;
    tick();
    in_valid = 1'b0;
    check("mid_occ2", occupancy, 2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_write", write, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_data", write_data, 0);
    tick();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rel_ready", in_ready, 1);
    check("mid_rel_occ", occupancy, 0);

    // Three writing results and one x0 result retire back to back.
    tick();
    rf_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 5'd1, 2'b00, 1'b0, 2'd0, 32'd100, 32'h0);
    tick();
    opReg = 5'd2;
    tick();
    opReg = 5'd0;
    tick();
    opReg = 5'd3;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("ret_occ", occupancy, 0);
`ifdef WB_RETIRE_CNT_EN
    check("ret_count", retired, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
